// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: two-master round-robin arbiter in front of a single
// peripheral bus. One transfer is in flight at a time. It completes on
// acknowledge or is abandoned after TIMEOUT bus cycles. Every output is
// registered.
module ext_bus_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_rw_i,
    input  logic [3:0]        m0_byte_enable_i,
    input  logic [31:0]       m0_write_data_i,
    output logic              m0_done_o,
    output logic              m0_err_o,
    output logic [31:0]       m0_read_data_o,

    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_rw_i,
    input  logic [3:0]        m1_byte_enable_i,
    input  logic [31:0]       m1_write_data_i,
    output logic              m1_done_o,
    output logic              m1_err_o,
    output logic [31:0]       m1_read_data_o,

    output logic [ADDR_W-1:0] bus_address_o,
    output logic              bus_enable_o,
    output logic [3:0]        bus_byte_enable_o,
    output logic              bus_rw_o,
    output logic [31:0]       bus_write_data_o,
    input  logic [31:0]       bus_read_data_i,
    input  logic              bus_acknowledge_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Counter value in the last permitted bus cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;   // 1: m1 was granted last, so m0 wins a tie
    logic              gnt_q, gnt_d;     // owner of the current transfer (0 = m0)
    logic [7:0]        cnt_q, cnt_d;

    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_en_q, bus_en_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              bus_rw_q, bus_rw_d;
    logic [31:0]       bus_wd_q, bus_wd_d;

    logic              m0_done_q, m0_done_d, m1_done_q, m1_done_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [31:0]       m0_rd_q, m0_rd_d, m1_rd_q, m1_rd_d;

    logic              any_req;
    logic              sel_m1;
    logic              acked;
    logic              timed_out;
    logic              finish;
    logic [31:0]       fin_rd;
    logic              fin_err;

    assign any_req   = m0_req_i | m1_req_i;
    // A tie goes to the master that was not served last.
    assign sel_m1    = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
    assign acked     = bus_acknowledge_i;
    // Acknowledge wins over a timeout in the same cycle.
    assign timed_out = ~bus_acknowledge_i & (cnt_q == TO_LAST);
    assign finish    = (state_q == S_BUS) & (acked | timed_out);
    assign fin_rd    = (acked & bus_rw_q) ? bus_read_data_i : 32'h0;
    assign fin_err   = ~acked;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_BUS;
            S_BUS:   if (acked || timed_out) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the output and bookkeeping registers
    always_comb begin
        last_d     = last_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        bus_addr_d = bus_addr_q;
        bus_en_d   = bus_en_q;
        bus_be_d   = bus_be_q;
        bus_rw_d   = bus_rw_q;
        bus_wd_d   = bus_wd_q;
        m0_done_d  = 1'b0;
        m1_done_d  = 1'b0;
        m0_err_d   = m0_err_q;
        m1_err_d   = m1_err_q;
        m0_rd_d    = m0_rd_q;
        m1_rd_d    = m1_rd_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d      = sel_m1;
                    last_d     = sel_m1;
                    cnt_d      = 8'd0;
                    bus_en_d   = 1'b1;
                    bus_addr_d = sel_m1 ? m1_addr_i        : m0_addr_i;
                    bus_rw_d   = sel_m1 ? m1_rw_i          : m0_rw_i;
                    bus_be_d   = sel_m1 ? m1_byte_enable_i : m0_byte_enable_i;
                    bus_wd_d   = sel_m1 ? m1_write_data_i  : m0_write_data_i;
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 8'd1;
                if (finish) begin
                    bus_en_d = 1'b0;
                    if (gnt_q) begin
                        m1_done_d = 1'b1;
                        m1_err_d  = fin_err;
                        m1_rd_d   = fin_rd;
                    end else begin
                        m0_done_d = 1'b1;
                        m0_err_d  = fin_err;
                        m0_rd_d   = fin_rd;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset drops any transfer silently
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            cnt_q      <= 8'd0;
            bus_addr_q <= '0;
            bus_en_q   <= 1'b0;
            bus_be_q   <= 4'h0;
            bus_rw_q   <= 1'b0;
            bus_wd_q   <= 32'h0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rd_q    <= 32'h0;
            m1_rd_q    <= 32'h0;
        end else begin
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            bus_addr_q <= bus_addr_d;
            bus_en_q   <= bus_en_d;
            bus_be_q   <= bus_be_d;
            bus_rw_q   <= bus_rw_d;
            bus_wd_q   <= bus_wd_d;
            m0_done_q  <= m0_done_d;
            m1_done_q  <= m1_done_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
            m0_rd_q    <= m0_rd_d;
            m1_rd_q    <= m1_rd_d;
        end
    end

    assign bus_address_o     = bus_addr_q;
    assign bus_enable_o      = bus_en_q;
    assign bus_byte_enable_o = bus_be_q;
    assign bus_rw_o          = bus_rw_q;
    assign bus_write_data_o  = bus_wd_q;
    assign m0_done_o         = m0_done_q;
    assign m0_err_o          = m0_err_q;
    assign m0_read_data_o    = m0_rd_q;
    assign m1_done_o         = m1_done_q;
    assign m1_err_o          = m1_err_q;
    assign m1_read_data_o    = m1_rd_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter. Master drivers push the expected completion
// for each request into per-master queues. A negedge monitor tracks the
// round-robin owner and plays the peripheral. It pops and compares on
// every done pulse.
module tb_ext_bus_arbiter;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [3:0]        be;
        logic [31:0]       wd;
        int                dly;   // ack is driven in bus cycle dly+1
        logic [31:0]       rd;
    } txn_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_a  [2];
    logic [ADDR_W-1:0] addr_a [2];
    logic              rw_a   [2];
    logic [3:0]        be_a   [2];
    logic [31:0]       wd_a   [2];
    logic              act    [2];
    txn_t              cur    [2];

    wire               m0_done, m1_done, m0_err, m1_err;
    wire [31:0]        m0_rd, m1_rd;
    wire [ADDR_W-1:0]  bus_addr;
    wire               bus_en, bus_rw;
    wire [3:0]         bus_be;
    wire [31:0]        bus_wd;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    exp_t exp0[$];
    exp_t exp1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ext_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .m0_req_i          (req_a[0]),
        .m0_addr_i         (addr_a[0]),
        .m0_rw_i           (rw_a[0]),
        .m0_byte_enable_i  (be_a[0]),
        .m0_write_data_i   (wd_a[0]),
        .m0_done_o         (m0_done),
        .m0_err_o          (m0_err),
        .m0_read_data_o    (m0_rd),
        .m1_req_i          (req_a[1]),
        .m1_addr_i         (addr_a[1]),
        .m1_rw_i           (rw_a[1]),
        .m1_byte_enable_i  (be_a[1]),
        .m1_write_data_i   (wd_a[1]),
        .m1_done_o         (m1_done),
        .m1_err_o          (m1_err),
        .m1_read_data_o    (m1_rd),
        .bus_address_o     (bus_addr),
        .bus_enable_o      (bus_en),
        .bus_byte_enable_o (bus_be),
        .bus_rw_o          (bus_rw),
        .bus_write_data_o  (bus_wd),
        .bus_read_data_i   (bus_rdata),
        .bus_acknowledge_i (bus_ack)
    );

    function automatic logic done_of(input int n);
        return (n == 1) ? m1_done : m0_done;
    endfunction
    function automatic logic err_of(input int n);
        return (n == 1) ? m1_err : m0_err;
    endfunction
    function automatic logic [31:0] rd_of(input int n);
        return (n == 1) ? m1_rd : m0_rd;
    endfunction
    // Cycles bus_enable stays high: until ack, or the full timeout window.
    function automatic int exp_len(input int dly);
        return (dly < TIMEOUT) ? dly + 1 : TIMEOUT;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Present a new request on master n and record its expected completion.
    task automatic issue(input int n, input int dly);
        txn_t t;
        exp_t e;
        t.addr = ADDR_W'($urandom);
        t.rw   = 1'($urandom);
        t.be   = 4'($urandom);
        t.wd   = $urandom;
        t.rd   = $urandom;
        t.dly  = (dly < 0) ? int'($urandom_range(0, TIMEOUT + 1)) : dly;
        cur[n]    = t;
        addr_a[n] = t.addr;
        rw_a[n]   = t.rw;
        be_a[n]   = t.be;
        wd_a[n]   = t.wd;
        req_a[n]  = 1'b1;
        act[n]    = 1'b1;
        e.err = (t.dly >= TIMEOUT);
        e.rd  = e.err ? 32'h0 : (t.rw ? t.rd : 32'h0);
        if (n == 1) exp1.push_back(e);
        else        exp0.push_back(e);
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done_of(n) && k < 300);
        if (k >= 300) chk($sformatf("m%0d_done_timeout", n), 32'(done_of(n)), 32'd1);
    endtask

    task automatic drop(input int n);
        req_a[n] = 1'b0;
        act[n]   = 1'b0;
    endtask

    // Random master: sometimes keeps req high straight into the next request.
    task automatic run_master(input int n, input int cnt);
        int gap;
        @(posedge clk); #1;
        for (int i = 0; i < cnt; i++) begin
            issue(n, -1);
            wait_done(n);
            @(posedge clk); #1;
            if (i == cnt - 1 || $urandom_range(0, 2) == 0) begin
                drop(n);
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
        drop(n);
    endtask

    // Monitor, reference model and peripheral
    initial begin : mon
        int   owner, cyc, en_len, g;
        logic be_prev, rst_last, last_m, fell;
        logic [1:0] snap;
        logic prv_err [2];
        logic [31:0] prv_rd [2];
        txn_t own_t;
        exp_t e;
        owner = -1; cyc = 0; en_len = 0; be_prev = 1'b0; rst_last = 1'b1;
        last_m = 1'b1; snap = 2'b00;
        prv_err[0] = 1'b0; prv_err[1] = 1'b0; prv_rd[0] = 32'h0; prv_rd[1] = 32'h0;
        own_t = '{default: 0};
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_last) begin
                chk("rst_bus_en", 32'(bus_en), 32'd0);
                chk("rst_bus_ctl", 32'({bus_addr, bus_be, bus_rw}), 32'd0);
                chk("rst_bus_wd", bus_wd, 32'd0);
                chk("rst_done_err", 32'({m1_done, m0_done, m1_err, m0_err}), 32'd0);
                chk("rst_m0_rd", m0_rd, 32'd0);
                chk("rst_m1_rd", m1_rd, 32'd0);
                last_m = 1'b1; owner = -1; cyc = 0; en_len = 0;
                exp0.delete(); exp1.delete();
                prv_err[0] = 1'b0; prv_err[1] = 1'b0; prv_rd[0] = 32'h0; prv_rd[1] = 32'h0;
            end else begin
                fell = be_prev && !bus_en;
                if (bus_en && !be_prev) begin
                    chk("grant_had_req", 32'(snap != 2'b00), 32'd1);
                    g = (snap == 2'b11) ? (last_m ? 0 : 1) : (snap[1] ? 1 : 0);
                    last_m = (g == 1);
                    owner = g; own_t = cur[g]; cyc = 0; en_len = 0;
                end
                if (bus_en) begin
                    en_len++;
                    chk("bus_addr", 32'(bus_addr), 32'(own_t.addr));
                    chk("bus_ctl", 32'({bus_be, bus_rw}), 32'({own_t.be, own_t.rw}));
                    chk("bus_wd", bus_wd, own_t.wd);
                end
                if (fell) chk("bus_en_len", 32'(en_len), 32'(exp_len(own_t.dly)));
                for (int n = 0; n < 2; n++) begin
                    chk($sformatf("m%0d_done", n), 32'(done_of(n)), 32'(fell && owner == n));
                    if (done_of(n)) begin
                        if ((n == 1 ? exp1.size() : exp0.size()) == 0) begin
                            chk($sformatf("m%0d_unexpected_done", n), 32'd1, 32'd0);
                        end else begin
                            e = (n == 1) ? exp1.pop_front() : exp0.pop_front();
                            chk($sformatf("m%0d_err", n), 32'(err_of(n)), 32'(e.err));
                            chk($sformatf("m%0d_rd", n), rd_of(n), e.rd);
                        end
                        prv_err[n] = err_of(n);
                        prv_rd[n]  = rd_of(n);
                    end else begin
                        chk($sformatf("m%0d_err_hold", n), 32'(err_of(n)), 32'(prv_err[n]));
                        chk($sformatf("m%0d_rd_hold", n), rd_of(n), prv_rd[n]);
                    end
                end
                if (owner >= 0) cyc++;
            end
            rst_last  = rst;
            snap      = {act[1], act[0]};
            be_prev   = bus_en;
            bus_ack   = (owner >= 0) && (cyc == own_t.dly + 1);
            bus_rdata = (owner >= 0) ? own_t.rd : $urandom;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int dlys[6];
        int k;
        for (int n = 0; n < 2; n++) begin
            req_a[n] = 1'b0; addr_a[n] = '0; rw_a[n] = 1'b0; be_a[n] = 4'h0;
            wd_a[n] = 32'h0; act[n] = 1'b0; cur[n] = '{default: 0};
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed ack/timeout boundaries, alternating masters
        dlys = '{0, 4, TIMEOUT - 1, TIMEOUT, TIMEOUT + 1, 2};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            issue(i % 2, dlys[i]);
            wait_done(i % 2);
            @(posedge clk); #1;
            drop(i % 2);
        end

        // Both masters competing with random traffic
        fork
            run_master(0, 25);
            run_master(1, 25);
        join

        // Reset in the middle of an m1 transfer, then a tie must go to m0
        repeat (3) @(posedge clk);
        #1 issue(1, TIMEOUT + 1);
        k = 0;
        while (!bus_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("pre_reset_bus_en", 32'(bus_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drop(1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(0, 1);
        issue(1, 3);
        wait_done(0);
        @(posedge clk); #1;
        drop(0);
        wait_done(1);
        @(posedge clk); #1;
        drop(1);

        repeat (5) @(posedge clk);
        #1;
        chk("m0_queue_empty", 32'(exp0.size()), 32'd0);
        chk("m1_queue_empty", 32'(exp1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
